// File: rtl/fifo_pkg.sv
// Shared constants and Gray/binary pointer helpers for the asynchronous FIFO.
package fifo_pkg;

    localparam int DEF_ADD_SIZE = 4;
    localparam int DEF_DATA_W   = 8;
    localparam int PTR_W        = DEF_ADD_SIZE + 1;
    // Helpers work on a wide vector so any pointer width can be zero-extended into them.
    localparam int CONV_W       = 32;

    function automatic logic [CONV_W-1:0] gray2bin(input logic [CONV_W-1:0] g);
        logic [CONV_W-1:0] b;
        b[CONV_W-1] = g[CONV_W-1];
        for (int i = CONV_W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [CONV_W-1:0] bin2gray(input logic [CONV_W-1:0] b);
        return b ^ (b >> 1);
    endfunction

endpackage

// File: rtl/sync_r2w.sv
// Two-flop synchroniser carrying the read-domain Gray pointer into wclk.
module sync_r2w #(
    parameter int PTR_W = 5
) (
    input  logic             wclk,
    input  logic             wrst_n,
    input  logic [PTR_W-1:0] ptr_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] q1_q;
    logic [PTR_W-1:0] q2_q;

    // Metastability chain: no logic between the two stages.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            q1_q <= {PTR_W{1'b0}};
            q2_q <= {PTR_W{1'b0}};
        end else begin
            q1_q <= ptr_i;
            q2_q <= q1_q;
        end
    end

    assign ptr_o = q2_q;

endmodule

// File: rtl/wr_frontend.sv
// Write-side FIFO front end: 2-entry skid buffer feeding winc/wdata, rptr
// synchroniser, and a registered pessimistic fill level with almost-full flag.
module wr_frontend
    import fifo_pkg::*;
#(
    parameter int ADD_SIZE  = DEF_ADD_SIZE,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int AF_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   s_data,
    output logic                s_ready,
    input  logic [ADD_SIZE:0]   rptr,
    output logic [ADD_SIZE:0]   wq2_rptr,
    input  logic [ADD_SIZE:0]   wptr,
    input  logic                wfull,
    output logic                winc,
    output logic [DATA_W-1:0]   wdata,
    output logic [ADD_SIZE:0]   wlevel,
    output logic                walmost_full
);

    localparam int WPTR_W = ADD_SIZE + 1;

    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] head_q, head_d;
    logic [DATA_W-1:0] tail_q, tail_d;
    logic [WPTR_W-1:0] level_q, level_d;
    logic              af_q, af_d;
    logic              push_s;
    logic              pop_s;

    sync_r2w #(
        .PTR_W (WPTR_W)
    ) u_sync_r2w (
        .wclk   (wclk),
        .wrst_n (wrst_n),
        .ptr_i  (rptr),
        .ptr_o  (wq2_rptr)
    );

    // Ready depends only on occupancy, so the producer never sees a path from wfull.
    assign s_ready = (count_q != 2'd2);
    assign push_s  = s_valid & s_ready;
    assign winc    = (count_q != 2'd0) & ~wfull;
    assign pop_s   = winc;
    assign wdata   = head_q;

    // Skid queue next state: head is always the oldest word.
    always_comb begin
        count_d = count_q;
        head_d  = head_q;
        tail_d  = tail_q;
        case (count_q)
            2'd0: begin
                if (push_s) begin
                    head_d  = s_data;
                    count_d = 2'd1;
                end else begin
                    count_d = 2'd0;
                end
            end
            2'd1: begin
                if (push_s && pop_s) begin
                    head_d  = s_data;
                end else if (push_s) begin
                    tail_d  = s_data;
                    count_d = 2'd2;
                end else if (pop_s) begin
                    count_d = 2'd0;
                end else begin
                    count_d = 2'd1;
                end
            end
            2'd2: begin
                if (pop_s) begin
                    head_d  = tail_q;
                    count_d = 2'd1;
                end else begin
                    count_d = 2'd2;
                end
            end
            default: begin
                count_d = 2'd0;
            end
        endcase
    end

    // Modular subtraction absorbs pointer wrap; the stale rptr only ever over-reports.
    always_comb begin
        level_d = WPTR_W'(gray2bin(CONV_W'(wptr)) - gray2bin(CONV_W'(wq2_rptr)));
        af_d    = (level_d >= WPTR_W'(AF_THRESH));
    end

    // State registers; level and flag update together so they never disagree.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            count_q <= 2'd0;
            head_q  <= {DATA_W{1'b0}};
            tail_q  <= {DATA_W{1'b0}};
            level_q <= {WPTR_W{1'b0}};
            af_q    <= 1'b0;
        end else begin
            count_q <= count_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            level_q <= level_d;
            af_q    <= af_d;
        end
    end

    assign wlevel       = level_q;
    assign walmost_full = af_q;

endmodule

// File: tb/tb_wr_frontend.sv
// Directed self-checking bench for wr_frontend with a behavioural write-pointer counter.
module tb_wr_frontend;

    logic       wclk;
    logic       wrst_n;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ready;
    logic [4:0] rptr;
    logic [4:0] wq2_rptr;
    logic [4:0] wptr;
    logic       wfull;
    logic       winc;
    logic [7:0] wdata;
    logic [4:0] wlevel;
    logic       walmost_full;

    int         n_checks;
    int         n_fail;
    int         wcnt;
    int         wbase;
    logic [7:0] got_q[$];

    wr_frontend #(.ADD_SIZE(4), .DATA_W(8), .AF_THRESH(12)) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_ready      (s_ready),
        .rptr         (rptr),
        .wq2_rptr     (wq2_rptr),
        .wptr         (wptr),
        .wfull        (wfull),
        .winc         (winc),
        .wdata        (wdata),
        .wlevel       (wlevel),
        .walmost_full (walmost_full)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    function automatic logic [4:0] to_gray(input logic [4:0] b);
        return b ^ {1'b0, b[4:1]};
    endfunction

    // Write-pointer block stand-in: counts memory writes and records written data.
    always @(posedge wclk) begin
        if (winc) begin
            wcnt <= wcnt + 1;
            got_q.push_back(wdata);
        end
    end

    initial wcnt = 0;
    assign wptr = to_gray(5'(wcnt - wbase));

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge wclk);
        #1;
    endtask

    int         idx;
    int         qbase;
    int         prev_fill;
    int         fill;
    logic       rdy;
    logic [7:0] words[20];

    initial begin
        n_checks = 0;
        n_fail   = 0;
        wbase    = 0;
        wrst_n   = 1'b0;
        s_valid  = 1'b0;
        s_data   = 8'h00;
        rptr     = 5'd0;
        wfull    = 1'b0;
        for (int i = 0; i < 20; i++) words[i] = 8'(8'h10 + i);

        // 1. reset state
        tick();
        tick();
        check_eq("rst_s_ready", 32'(s_ready), 32'd1);
        check_eq("rst_winc", 32'(winc), 32'd0);
        check_eq("rst_wdata", 32'(wdata), 32'd0);
        check_eq("rst_wlevel", 32'(wlevel), 32'd0);
        check_eq("rst_af", 32'(walmost_full), 32'd0);
        check_eq("rst_wq2", 32'(wq2_rptr), 32'd0);
        wrst_n = 1'b1;

        // 2. single word
        qbase   = got_q.size();
        s_valid = 1'b1;
        s_data  = 8'hA5;
        check_eq("t2_ready", 32'(s_ready), 32'd1);
        tick();
        s_valid = 1'b0;
        s_data  = 8'h00;
        check_eq("t2_winc_on", 32'(winc), 32'd1);
        check_eq("t2_wdata", 32'(wdata), 32'hA5);
        tick();
        check_eq("t2_winc_off", 32'(winc), 32'd0);
        check_eq("t2_level_lag", 32'(wlevel), 32'd0);
        tick();
        check_eq("t2_level", 32'(wlevel), 32'd1);
        check_eq("t2_nwrites", 32'(got_q.size() - qbase), 32'd1);
        check_eq("t2_data", 32'(got_q[qbase]), 32'hA5);

        // 3. streaming into full with rptr frozen at 0
        wrst_n = 1'b0;
        tick();
        wbase  = wcnt;
        wrst_n = 1'b1;
        tick();
        qbase     = got_q.size();
        idx       = 0;
        prev_fill = 0;
        for (int c = 0; c < 26; c++) begin
            s_valid = (idx < 20);
            s_data  = (idx < 20) ? words[idx] : 8'h00;
            rdy     = s_ready;
            tick();
            if (rdy && idx < 20) idx++;
            fill = wcnt - wbase;
            wfull = (fill >= 16);
            check_eq("t3_level", 32'(wlevel), 32'(prev_fill));
            check_eq("t3_af", 32'(walmost_full), 32'(prev_fill >= 12));
            prev_fill = fill;
        end
        s_valid = 1'b0;
        check_eq("t3_accepted", 32'(idx), 32'd18);
        check_eq("t3_ready_low", 32'(s_ready), 32'd0);
        check_eq("t3_winc_held", 32'(winc), 32'd0);
        check_eq("t3_nwrites", 32'(got_q.size() - qbase), 32'd16);
        for (int i = 0; i < 16; i++) begin
            if (qbase + i < got_q.size()) check_eq("t3_order", 32'(got_q[qbase + i]), 32'(words[i]));
        end
        check_eq("t3_level16", 32'(wlevel), 32'd16);
        check_eq("t3_af16", 32'(walmost_full), 32'd1);

        // 4. rptr steps 0 -> 1 -> 3 (Gray), then full released
        rptr = 5'd1;
        tick();
        rptr = 5'd3;
        check_eq("t4_wq2_lag", 32'(wq2_rptr), 32'd0);
        tick();
        check_eq("t4_wq2_1", 32'(wq2_rptr), 32'd1);
        tick();
        check_eq("t4_wq2_3", 32'(wq2_rptr), 32'd3);
        check_eq("t4_level15", 32'(wlevel), 32'd15);
        tick();
        check_eq("t4_level14", 32'(wlevel), 32'd14);
        check_eq("t4_af14", 32'(walmost_full), 32'd1);
        check_eq("t4_hold", 32'(winc), 32'd0);
        qbase = got_q.size();
        wfull = 1'b0;
        #1;
        check_eq("t4_w16_winc", 32'(winc), 32'd1);
        check_eq("t4_w16", 32'(wdata), 32'(words[16]));
        tick();
        check_eq("t4_w17_winc", 32'(winc), 32'd1);
        check_eq("t4_w17", 32'(wdata), 32'(words[17]));
        tick();
        check_eq("t4_drained", 32'(winc), 32'd0);
        check_eq("t4_nwrites", 32'(got_q.size() - qbase), 32'd2);
        if (got_q.size() >= qbase + 2) begin
            check_eq("t4_q16", 32'(got_q[qbase]), 32'(words[16]));
            check_eq("t4_q17", 32'(got_q[qbase + 1]), 32'(words[17]));
        end

        // 5. wrap-around and threshold boundary, synced rptr binary 28
        wfull = 1'b1;
        rptr  = 5'b10010;
        wbase = wcnt - 30;
        tick();
        tick();
        tick();
        check_eq("t5_wq2", 32'(wq2_rptr), 32'b10010);
        check_eq("t5_level2", 32'(wlevel), 32'd2);
        wbase = wcnt - 33;
        tick();
        check_eq("t5_wrap5", 32'(wlevel), 32'd5);
        check_eq("t5_af5", 32'(walmost_full), 32'd0);
        wbase = wcnt - 39;
        tick();
        check_eq("t5_level11", 32'(wlevel), 32'd11);
        check_eq("t5_af11", 32'(walmost_full), 32'd0);
        wbase = wcnt - 40;
        tick();
        check_eq("t5_level12", 32'(wlevel), 32'd12);
        check_eq("t5_af12", 32'(walmost_full), 32'd1);

        // 6. reset while two words are buffered and winc is high
        wfull   = 1'b1;
        s_valid = 1'b1;
        s_data  = 8'hC1;
        tick();
        s_data  = 8'hC2;
        tick();
        s_valid = 1'b0;
        check_eq("t6_full_buf", 32'(s_ready), 32'd0);
        wfull = 1'b0;
        #1;
        check_eq("t6_winc_pre", 32'(winc), 32'd1);
        check_eq("t6_wdata_pre", 32'(wdata), 32'hC1);
        qbase  = got_q.size();
        wrst_n = 1'b0;
        #1;
        check_eq("t6_winc_rst", 32'(winc), 32'd0);
        check_eq("t6_ready_rst", 32'(s_ready), 32'd1);
        check_eq("t6_level_rst", 32'(wlevel), 32'd0);
        check_eq("t6_af_rst", 32'(walmost_full), 32'd0);
        tick();
        tick();
        wrst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check_eq("t6_no_winc", 32'(winc), 32'd0);
        end
        check_eq("t6_no_writes", 32'(got_q.size() - qbase), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/wr_frontend.md
Name: wr_frontend

Overview:
Write-side front end of the asynchronous FIFO. It sits directly upstream of the write-pointer/full block. It accepts producer data on a valid/ready handshake into a 2-entry skid buffer and drives winc/wdata toward the write-pointer block and the dual-port memory. It also synchronises the read-domain Gray pointer into wclk, which produces wq2_rptr for the write-pointer block. From the synchronised pointer it computes a registered fill level and an almost-full flag.

Parameters:
ADD_SIZE, 4, FIFO address width; depth = 2**ADD_SIZE; pointers are ADD_SIZE+1 bits
DATA_W, 8, data word width
AF_THRESH, 12, walmost_full asserts when wlevel >= AF_THRESH (legal range 1..2**ADD_SIZE)

Ports:
wclk  in  1  write-domain clock
wrst_n  in  1  asynchronous active-low reset
s_valid  in  1  producer data valid
s_data  in  DATA_W  producer data
s_ready  out  1  front end can accept a word this cycle
rptr  in  ADD_SIZE+1  read-domain Gray read pointer (asynchronous to wclk)
wq2_rptr  out  ADD_SIZE+1  2-flop synchronised rptr, sent to the write-pointer block
wptr  in  ADD_SIZE+1  Gray write pointer from the write-pointer block
wfull  in  1  registered full flag from the write-pointer block
winc  out  1  write request; a memory write occurs when winc is high
wdata  out  DATA_W  data to the memory write port; valid when winc=1
wlevel  out  ADD_SIZE+1  registered, pessimistic fill level
walmost_full  out  1  registered almost-full flag

Behaviour:
- Reset (wrst_n low, asynchronous): skid count=0; both skid entries=0; sync flops=0; wlevel=0; walmost_full=0. Outputs during reset: winc=0, wdata=0, wq2_rptr=0, s_ready=1.
- Synchroniser: two flops, rptr -> q1 -> wq2_rptr. No logic between the flops. Latency is 2 wclk edges.
- Skid buffer: 2-entry in-order queue with head and tail entries; count is 0, 1 or 2.
- s_ready = (count != 2). It is derived only from registered state and has no combinational path from s_valid or wfull.
- push = s_valid & s_ready.
- winc = (count != 0) & ~wfull.
- pop = winc.
- wdata = head entry.
- Count update per edge:
  - push only: count+1.
  - pop only: count-1.
  - push and pop together: count unchanged. The head advances and the new word is enqueued behind it.
  - At count=0 a push always lands in the head, and the word cannot be written in the same cycle.
- Latency: a word accepted at edge N is presented with winc=1 in the cycle after edge N if wfull=0. It is written at edge N+1.
- Full: while wfull=1, winc=0 and the buffer holds. Up to 2 further words are accepted, then s_ready drops. There is no loss and no duplication. Writes resume in the first cycle wfull=0.
- Level: wlevel <= (gray2bin(wptr) - gray2bin(wq2_rptr)), modulo 2**(ADD_SIZE+1).
  - This is registered, so it lags wptr by 1 cycle and rptr by 3 cycles.
  - Because the read pointer is stale, the level may over-report but never under-reports.
  - The range is 0..2**ADD_SIZE. Pointer wrap-around is handled by the modular subtraction. A value of 2**ADD_SIZE means full.
- walmost_full <= (next wlevel >= AF_THRESH). It is registered in the same cycle as wlevel, so the flag and the level are always consistent.
- Words held in the skid buffer are not counted in wlevel.
- Reset mid-operation: skid contents are discarded and all state returns to the reset values immediately. No winc pulse occurs after reset assertion.
- s_data is sampled only on push. Behaviour for s_data is don't-care when s_valid=0.

Decomposition:
- Package fifo_pkg:
  - default ADD_SIZE and DATA_W constants.
  - pointer-width localparam PTR_W = ADD_SIZE+1.
  - function gray2bin (XOR-prefix reduction from the MSB).
  - function bin2gray (b ^ (b>>1)).
- One sub-module, sync_r2w: a parameterised PTR_W-bit 2-flop synchroniser clocked by wclk and reset by wrst_n. It is instantiated once, for rptr.
- The skid buffer, level calculation and almost-full logic stay inline.

Test Plan:
1. Reset with s_valid=0 and rptr=0 -> s_ready=1, winc=0, wlevel=0, walmost_full=0, wq2_rptr=0.
2. Single word 0xA5 with wfull=0 -> winc=1 and wdata=0xA5 for exactly one cycle, starting the cycle after acceptance. When wptr advances 0->1, wlevel reads 1 one cycle later.
3. Streaming 20 words with wfull forced high at word 16 and rptr frozen at 0 -> 16 winc pulses; 2 more words accepted, then s_ready=0. walmost_full rises when wlevel=12. wlevel reaches 16.
4. Release the full condition by stepping rptr Gray through 0,1,3 (binary 2) -> wq2_rptr follows 2 cycles later; wlevel drops 16->14; walmost_full stays 1 (14>=12). When wfull deasserts, the 2 buffered words come out in order.
5. Wrap-around check with wptr binary 30->1 (wrapped) and synced rptr binary 28 -> wlevel=(1-28) mod 32=5.
6. Assert wrst_n low while count=2 and winc=1 -> winc=0 immediately, s_ready=1, wlevel=0. After reset is released, the old words never appear.
